// File: rtl/vector_alu_pipe.sv
// Pipelined lane-wise SIMD ALU with valid/ready handshakes, per-lane masking,
// immediate broadcast and a flags register updated when a result retires.
module vector_alu_pipe #(
    parameter int unsigned LANES      = 6,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [2:0]               i_op,
    input  logic [LANES*WIDTH-1:0]   i_src_a,
    input  logic [LANES*WIDTH-1:0]   i_src_b,
    input  logic [WIDTH-1:0]         i_imm,
    input  logic                     i_alu_src,
    input  logic [LANES-1:0]         i_lane_mask,
    input  logic                     i_flags_write,
    input  logic [TAG_W-1:0]         i_tag_in,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [LANES*WIDTH-1:0]   o_result,
    output logic [2*LANES-1:0]       o_flags,
    output logic [TAG_W-1:0]         o_tag_out,
    output logic [2*LANES-1:0]       o_flags_q
);

    localparam int unsigned LAT  = 1 + MUL_STAGES;
    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam int unsigned VW   = LANES * WIDTH;
    localparam int unsigned FW   = 2 * LANES;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMov = 3'b010;
    localparam logic [2:0] OpMul = 3'b011;
    localparam logic [2:0] OpAnd = 3'b100;
    localparam logic [2:0] OpOr  = 3'b101;
    localparam logic [2:0] OpXor = 3'b110;
    localparam logic [2:0] OpShl = 3'b111;

    // Returns {carry, result} for one lane.
    function automatic logic [WIDTH:0] lane_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0]     sum;
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH:0]     shl;
        sum  = {1'b0, a} + {1'b0, b};
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        // Bit WIDTH of the widened shift is the last bit pushed out of the lane.
        shl  = {1'b0, a} << b[SH_W-1:0];
        case (op)
            OpAdd:   lane_op = sum;
            OpSub:   lane_op = {(a < b), a - b};
            OpMov:   lane_op = {1'b0, b};
            OpMul:   lane_op = {(prod[2*WIDTH-1:WIDTH] != '0), prod[WIDTH-1:0]};
            OpAnd:   lane_op = {1'b0, a & b};
            OpOr:    lane_op = {1'b0, a | b};
            OpXor:   lane_op = {1'b0, a ^ b};
            OpShl:   lane_op = shl;
            default: lane_op = '0;
        endcase
    endfunction

    logic [VW-1:0] w_res;
    logic [FW-1:0] w_flg;
    logic          w_advance;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH:0]   w_op;

        assign w_a  = i_src_a[i*WIDTH +: WIDTH];
        assign w_b  = i_alu_src ? i_imm : i_src_b[i*WIDTH +: WIDTH];
        assign w_op = lane_op(i_op, w_a, w_b);

        assign w_res[i*WIDTH +: WIDTH] = i_lane_mask[i] ? w_op[WIDTH-1:0] : w_a;
        assign w_flg[2*i]              = i_lane_mask[i] & (w_op[WIDTH-1:0] == '0);
        assign w_flg[2*i+1]            = i_lane_mask[i] & w_op[WIDTH];
    end

    logic [LAT-1:0]            r_valid;
    logic [LAT-1:0]            r_fw;
    logic [LAT-1:0][VW-1:0]    r_data;
    logic [LAT-1:0][FW-1:0]    r_flg;
    logic [LAT-1:0][TAG_W-1:0] r_tag;
    logic [FW-1:0]             r_flags_q;

    // The whole pipe moves as one; a held output freezes every stage.
    assign w_advance = !r_valid[LAT-1] || i_out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid   <= '0;
            r_fw      <= '0;
            r_data    <= '0;
            r_flg     <= '0;
            r_tag     <= '0;
            r_flags_q <= '0;
        end else begin
            if (w_advance) begin
                r_valid[0] <= i_in_valid;
                r_fw[0]    <= i_flags_write;
                r_data[0]  <= w_res;
                r_flg[0]   <= w_flg;
                r_tag[0]   <= i_tag_in;
                for (int s = 1; s < LAT; s++) begin
                    r_valid[s] <= r_valid[s-1];
                    r_fw[s]    <= r_fw[s-1];
                    r_data[s]  <= r_data[s-1];
                    r_flg[s]   <= r_flg[s-1];
                    r_tag[s]   <= r_tag[s-1];
                end
            end
            if (r_valid[LAT-1] && i_out_ready && r_fw[LAT-1]) begin
                r_flags_q <= r_flg[LAT-1];
            end
        end
    end

    assign o_in_ready  = w_advance;
    assign o_out_valid = r_valid[LAT-1];
    assign o_result    = r_data[LAT-1];
    assign o_flags     = r_flg[LAT-1];
    assign o_tag_out   = r_tag[LAT-1];
    assign o_flags_q   = r_flags_q;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe: directed vectors push expected results,
// a monitor pops and compares each retiring output.
module tb_vector_alu_pipe;

    localparam int LANES = 6;
    localparam int WIDTH = 8;
    localparam int MULS  = 2;
    localparam int TAG_W = 4;
    localparam int LAT   = 1 + MULS;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MOV = 3'd2, MUL = 3'd3;
    localparam logic [2:0] AND = 3'd4, OR_ = 3'd5, XOR = 3'd6, SHL = 3'd7;

    logic                   clk, rst_n;
    logic                   in_valid, in_ready;
    logic [2:0]             op;
    logic [LANES*WIDTH-1:0] src_a, src_b;
    logic [WIDTH-1:0]       imm;
    logic                   alu_src;
    logic [LANES-1:0]       lane_mask;
    logic                   flags_write;
    logic [TAG_W-1:0]       tag_in;
    logic                   out_valid, out_ready;
    logic [LANES*WIDTH-1:0] result;
    logic [2*LANES-1:0]     flags;
    logic [TAG_W-1:0]       tag_out;
    logic [2*LANES-1:0]     flags_q;

    vector_alu_pipe #(
        .LANES(LANES), .WIDTH(WIDTH), .MUL_STAGES(MULS), .TAG_W(TAG_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op(op), .i_src_a(src_a), .i_src_b(src_b), .i_imm(imm), .i_alu_src(alu_src),
        .i_lane_mask(lane_mask), .i_flags_write(flags_write), .i_tag_in(tag_in),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
        .o_flags(flags), .o_tag_out(tag_out), .o_flags_q(flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] res;
        logic [11:0] flg;
        logic [3:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   lat_chk  = 1'b1;

    function automatic logic [47:0] vec(input logic [7:0] l5, l4, l3, l2, l1, l0);
        return {l5, l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [47:0] spl(input logic [7:0] x);
        return {6{x}};
    endfunction

    function automatic logic [11:0] fl(input logic [5:0] z, input logic [5:0] c);
        logic [11:0] f;
        for (int i = 0; i < 6; i++) begin
            f[2*i]   = z[i];
            f[2*i+1] = c[i];
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {60'd0, tag_out}, 64'hdead);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("result_tag%0d", e.tag), {16'd0, result}, {16'd0, e.res});
                    chk($sformatf("flags_tag%0d", e.tag), {52'd0, flags}, {52'd0, e.flg});
                    chk("tag_order", {60'd0, tag_out}, {60'd0, e.tag});
                    if (e.lat) chk($sformatf("latency_tag%0d", e.tag), 64'(cyc - e.cyc), 64'(LAT));
                end
            end
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [47:0] a, input logic [47:0] b,
                         input logic [7:0] im, input logic as, input logic [5:0] m,
                         input logic fw, input logic [3:0] t,
                         input logic [47:0] eres, input logic [11:0] eflg);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        op = o; src_a = a; src_b = b; imm = im; alu_src = as;
        lane_mask = m; flags_write = fw; tag_in = t; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'd0, 64'd1);
        end else begin
            e.res = eres; e.flg = eflg; e.tag = t; e.cyc = cyc; e.lat = lat_chk;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [47:0] va, vb;
    bit          stale;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0; imm = '0;
        alu_src = 1'b0; lane_mask = '1; flags_write = 1'b0; tag_in = '0; out_ready = 1'b1;
        stale = 1'b0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {16'd0, result}, 64'd0);
        chk("rst_flags", {52'd0, flags}, 64'd0);
        chk("rst_tag_out", {60'd0, tag_out}, 64'd0);
        chk("rst_flags_q", {52'd0, flags_q}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk) rst_n = 1'b1;

        // Back-to-back basic ops
        va = vec(15, 14, 13, 12, 11, 10);
        vb = vec(5, 4, 3, 2, 1, 0);
        issue(ADD, va, vb, 0, 0, '1, 0, 0, vec(20, 18, 16, 14, 12, 10), fl(0, 0));
        issue(SUB, va, vb, 0, 0, '1, 0, 1, spl(10), fl(0, 0));
        issue(MOV, va, vb, 0, 0, '1, 0, 2, vb, fl(6'b000001, 0));
        issue(MUL, va, vb, 0, 0, '1, 0, 3, vec(75, 56, 39, 24, 11, 0), fl(6'b000001, 0));

        // Carry / boundary cases
        issue(ADD, spl(8'hFF), spl(8'h01), 0, 0, '1, 0, 4, spl(8'h00), fl('1, '1));
        issue(SUB, spl(8'h01), spl(8'h02), 0, 0, '1, 0, 5, spl(8'hFF), fl(0, '1));
        issue(MUL, spl(8'h10), spl(8'h10), 0, 0, '1, 0, 6, spl(8'h00), fl('1, '1));
        issue(SHL, spl(8'h81), spl(8'h01), 0, 0, '1, 0, 7, spl(8'h02), fl(0, '1));
        issue(SHL, spl(8'h81), spl(8'h08), 0, 0, '1, 0, 8, spl(8'h81), fl(0, 0));
        issue(XOR, spl(8'hF0), spl(8'hFF), 0, 0, '1, 0, 9, spl(8'h0F), fl(0, 0));
        issue(AND, va, spl(8'h0C), 0, 0, '1, 0, 10, vec(12, 12, 12, 12, 8, 8), fl(0, 0));
        issue(OR_, spl(8'h00), spl(8'h00), 0, 0, '1, 0, 11, spl(8'h00), fl('1, 0));

        // Immediate broadcast and masking
        issue(ADD, va, spl(8'd99), 8'd3, 1, 6'b101010, 0, 12,
              vec(18, 14, 16, 12, 14, 10), fl(0, 0));
        issue(ADD, spl(8'hFF), spl(8'h01), 0, 0, 6'b000011, 0, 13,
              vec(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0), fl(6'b000011, 6'b000011));
        issue(MUL, va, spl(8'hAA), 8'd2, 1, '1, 0, 14, vec(30, 28, 26, 24, 22, 20), fl(0, 0));
        drain();

        // Backpressure: output held low while five ops are offered
        lat_chk = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                for (int t = 0; t < 5; t++)
                    issue(ADD, spl(8'(t * 10 + 1)), spl(8'd2), 0, 0, '1, 0, 4'(t),
                          spl(8'(t * 10 + 3)), fl(0, 0));
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
                chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Architectural flags register
        chk("flags_q_untouched", {52'd0, flags_q}, 64'd0);
        issue(ADD, spl(8'hFF), spl(8'h01), 0, 0, '1, 1, 5, spl(8'h00), fl('1, '1));
        drain();
        chk("flags_q_set", {52'd0, flags_q}, {52'd0, fl('1, '1)});
        issue(XOR, spl(8'h0F), spl(8'hF0), 0, 0, '1, 0, 6, spl(8'hFF), fl(0, 0));
        drain();
        chk("flags_q_hold", {52'd0, flags_q}, {52'd0, fl('1, '1)});
        issue(ADD, spl(8'h01), spl(8'h01), 0, 0, '1, 1, 7, spl(8'h02), fl(0, 0));
        drain();
        chk("flags_q_replace", {52'd0, flags_q}, 64'd0);

        // Reset with operations in flight
        issue(ADD, spl(8'hFF), spl(8'h01), 0, 0, '1, 1, 8, spl(8'h00), fl('1, '1));
        drain();
        chk("flags_q_preset", {52'd0, flags_q}, {52'd0, fl('1, '1)});
        issue(ADD, spl(8'd1), spl(8'd2), 0, 0, '1, 0, 9, spl(8'd3), fl(0, 0));
        issue(ADD, spl(8'd4), spl(8'd2), 0, 0, '1, 0, 10, spl(8'd6), fl(0, 0));
        issue(ADD, spl(8'd7), spl(8'd2), 0, 0, '1, 0, 11, spl(8'd9), fl(0, 0));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_result", {16'd0, result}, 64'd0);
        chk("midrst_flags_q", {52'd0, flags_q}, 64'd0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("no_stale_result", {63'd0, stale}, 64'd0);

        issue(ADD, spl(8'd1), spl(8'd1), 0, 0, '1, 0, 3, spl(8'd2), fl(0, 0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
